// File: rtl/cic_decimator.sv
// cic_decimator: N-order CIC decimator for a 1-bit sigma-delta stream.
// Runtime ratio/shift, saturated output with valid strobe and overflow.
//
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   clear_i              sync clear of datapath, loads rate_q from rate_i
//   in_valid_i           modulator_data_i valid this cycle
//   modulator_data_i     modulator bit (0 -> +0, 1 -> +1)
//   rate_i               decimation ratio, applied from the next period
//   shift_i              right shift of comb result, captured per sample
//   out_valid_o          one-cycle strobe for cic_o/ovf_o
//   cic_o                scaled, saturated sample (holds between strobes)
//   ovf_o                sample saturated (qualified by out_valid_o)
// Optional CIC_DEBUG_EN: integrator_o, comb_o, decimation_counter_o,
//   cic_clk_o (high while counter >= R/2).

module cic_decimator #(
  parameter  int order        = 3,
  parameter  int rate_width   = 8,
  parameter  int output_width = 16,
  parameter  int default_rate = 64,
  localparam int W            = order * rate_width + 1,
  localparam int SW           = $clog2(W + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  input  logic                    modulator_data_i,
  input  logic [rate_width-1:0]   rate_i,
  input  logic [SW-1:0]           shift_i,
  output logic                    out_valid_o,
  output logic [output_width-1:0] cic_o,
  output logic                    ovf_o
`ifdef CIC_DEBUG_EN
  ,
  output logic [W-1:0]            integrator_o,
  output logic [W-1:0]            comb_o,
  output logic [rate_width-1:0]   decimation_counter_o,
  output logic                    cic_clk_o
`endif
);

  localparam int WX = (W > output_width) ? W : output_width;
  localparam logic [SW-1:0] LW = SW'(W);

  logic [W-1:0]          r_integ [order];
  logic [W-1:0]          r_cdly  [order];
  logic [W-1:0]          r_cres  [order];
  logic [W-1:0]          r_decim;
  logic [SW-1:0]         r_shift;
  logic [rate_width-1:0] r_cnt;
  logic [rate_width-1:0] r_rate;
  logic [order+1:0]      r_vld;

  logic [rate_width-1:0] w_rate;
  logic                  w_wrap;
  logic [W-1:0]          w_cin [order];
  logic [W-1:0]          w_sh;
  logic [WX-1:0]         w_yx;
  logic [WX-1:0]         w_max;
  logic                  w_ovf;

  // Ratios 0 and 1 cannot be pipelined; treat them as 2.
  assign w_rate = (r_rate < rate_width'(2)) ? rate_width'(2) : r_rate;
  assign w_wrap = in_valid_i && (r_cnt == (w_rate - rate_width'(1)));

  always_comb begin
    w_cin[0] = r_decim;
    for (int k = 1; k < order; k++) begin
      w_cin[k] = r_cres[k-1];
    end
  end

  // Comb result is non-negative; shifts past the width flush to zero.
  assign w_sh  = (r_shift >= LW) ? '0 : (r_cres[order-1] >> r_shift);
  assign w_yx  = WX'(w_sh);
  assign w_max = WX'({output_width{1'b1}});
  assign w_ovf = (w_yx > w_max);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < order; k++) begin
        r_integ[k] <= '0;
        r_cdly[k]  <= '0;
        r_cres[k]  <= '0;
      end
      r_decim <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_rate  <= rate_width'(default_rate);
      r_vld   <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < order; k++) begin
        r_integ[k] <= '0;
        r_cdly[k]  <= '0;
        r_cres[k]  <= '0;
      end
      r_decim <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_rate  <= rate_i;
      r_vld   <= '0;
    end else begin
      if (in_valid_i) begin
        r_integ[0] <= r_integ[0] + {{(W-1){1'b0}}, modulator_data_i};
        // Pipelined chain: each stage adds the previous stage's old value.
        for (int k = 1; k < order; k++) begin
          r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
        if (w_wrap) begin
          r_cnt  <= '0;
          r_rate <= rate_i;
        end else begin
          r_cnt <= r_cnt + rate_width'(1);
        end
      end
      r_vld <= {r_vld[order:0], w_wrap};
      if (r_vld[0]) begin
        r_decim <= r_integ[order-1];
        r_shift <= shift_i;
      end
      for (int k = 0; k < order; k++) begin
        if (r_vld[k+1]) begin
          r_cres[k] <= w_cin[k] - r_cdly[k];
          r_cdly[k] <= w_cin[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      cic_o       <= '0;
      ovf_o       <= 1'b0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= r_vld[order+1];
      if (r_vld[order+1]) begin
        cic_o <= w_ovf ? '1 : w_yx[output_width-1:0];
        ovf_o <= w_ovf;
      end
    end
  end

`ifdef CIC_DEBUG_EN
  assign integrator_o         = r_integ[order-1];
  assign comb_o               = r_cdly[order-1];
  assign decimation_counter_o = r_cnt;
  assign cic_clk_o            = (r_cnt >= (w_rate >> 1));
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed + randomized bench for cic_decimator.
// Reference: N-th difference of N-fold running sums at decimation points.

module tb_cic_decimator;

  localparam int N  = 3;
  localparam int RW = 8;
  localparam int OW = 16;
  localparam int W  = N * RW + 1;
  localparam int SW = $clog2(W + 1);

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          clear_i;
  logic          in_valid_i;
  logic          modulator_data_i;
  logic [RW-1:0] rate_i;
  logic [SW-1:0] shift_i;
  logic          out_valid_o;
  logic [OW-1:0] cic_o;
  logic          ovf_o;
`ifdef CIC_DEBUG_EN
  logic [W-1:0]  integrator_o;
  logic [W-1:0]  comb_o;
  logic [RW-1:0] decimation_counter_o;
  logic          cic_clk_o;
`endif

  cic_decimator #(
    .order(N), .rate_width(RW), .output_width(OW), .default_rate(64)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .clear_i(clear_i),
    .in_valid_i(in_valid_i),
    .modulator_data_i(modulator_data_i),
    .rate_i(rate_i),
    .shift_i(shift_i),
    .out_valid_o(out_valid_o),
    .cic_o(cic_o),
    .ovf_o(ovf_o)
`ifdef CIC_DEBUG_EN
    ,
    .integrator_o(integrator_o),
    .comb_o(comb_o),
    .decimation_counter_o(decimation_counter_o),
    .cic_clk_o(cic_clk_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int     when;
    longint val;
    bit     ovf;
  } exp_t;

  bit     xs[$];
  longint ds[$];
  exp_t   pend[$];
  int     cnt;
  int     rq;
  int     cyc;
  longint last_cic;
  bit     last_ovf;
  int     ntests;
  int     nfail;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r;
    if (k < 0 || n < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Value of an N-fold running sum after p accepted samples.
  function automatic longint integ_at(input int p);
    longint s;
    s = 0;
    for (int i = 0; i < p; i++) begin
      if (xs[i]) s += binom(p - 1 - i, N - 1);
    end
    return s;
  endfunction

  function automatic int clampr(input logic [RW-1:0] r);
    return (r < 2) ? 2 : int'(r);
  endfunction

  task automatic decimate();
    longint y;
    longint t;
    longint mask;
    int     m;
    int     sh;
    exp_t   e;
    ds.push_back(integ_at(xs.size()));
    m    = ds.size() - 1;
    y    = 0;
    mask = (longint'(1) << W) - 1;
    for (int k = 0; k <= N; k++) begin
      if (m - k >= 0) begin
        t = binom(N, k) * ds[m-k];
        y = (k % 2 == 1) ? y - t : y + t;
      end
    end
    y  = y & mask;
    sh = int'(shift_i);
    y  = (sh >= W) ? 0 : (y >> sh);
    e.when = cyc + N + 2;
    if (y > 65535) begin
      e.val = 65535;
      e.ovf = 1'b1;
    end else begin
      e.val = y;
      e.ovf = 1'b0;
    end
    pend.push_back(e);
  endtask

  task automatic check_outputs();
    if (pend.size() > 0 && pend[0].when == cyc) begin
      chk("strobe", 64'(out_valid_o), 64'(1));
      chk("cic", 64'(cic_o), 64'(pend[0].val));
      chk("ovf", 64'(ovf_o), 64'(pend[0].ovf));
      last_cic = pend[0].val;
      last_ovf = pend[0].ovf;
      void'(pend.pop_front());
    end else begin
      chk("idle_valid", 64'(out_valid_o), 64'(0));
      chk("hold_cic", 64'(cic_o), 64'(last_cic));
      chk("hold_ovf", 64'(ovf_o), 64'(last_ovf));
    end
  endtask

  task automatic step(input bit v, input bit d, input bit clr);
    in_valid_i       = v;
    modulator_data_i = d;
    clear_i          = clr;
    @(posedge clk_i);
    cyc++;
    if (clr) begin
      pend.delete();
      xs.delete();
      ds.delete();
      cnt = 0;
      rq  = clampr(rate_i);
    end else if (v) begin
      xs.push_back(d);
      cnt++;
      if (cnt == rq) begin
        cnt = 0;
        rq  = clampr(rate_i);
        decimate();
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    pend.delete();
    xs.delete();
    ds.delete();
    cnt      = 0;
    rq       = 64;
    last_cic = 0;
    last_ovf = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'(0));
    chk({tag, "_cic"}, 64'(cic_o), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf_o), 64'(0));
`ifdef CIC_DEBUG_EN
    chk({tag, "_dbg_cnt"}, 64'(decimation_counter_o), 64'(0));
    chk({tag, "_dbg_clk"}, 64'(cic_clk_o), 64'(0));
`endif
  endtask

  initial begin
    ntests           = 0;
    nfail            = 0;
    cyc              = 0;
    rstn_i           = 1'b0;
    clear_i          = 1'b0;
    in_valid_i       = 1'b0;
    modulator_data_i = 1'b0;
    rate_i           = 8'd4;
    shift_i          = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_checks("reset");
    rstn_i = 1'b1;

    // Default ratio after reset is 64.
    repeat (140) step(1'b1, 1'b1, 1'b0);

    // R=4: all ones, then alternating, then random dense.
    rate_i = 8'd4;
    step(1'b0, 1'b0, 1'b1);
    repeat (40) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'(i % 2), 1'b0);
    repeat (60) step(1'b1, 1'($urandom), 1'b0);

    // Sparse input: one valid in three cycles.
    for (int i = 0; i < 72; i++) step(i % 3 == 0, 1'($urandom), 1'b0);

    // Ratio change mid-period, then clamped ratios.
    repeat (2) step(1'b1, 1'b1, 1'b0);
    rate_i = 8'd8;
    repeat (60) step(1'b1, 1'($urandom), 1'b0);
    rate_i = 8'd1;
    repeat (20) step(1'b1, 1'b1, 1'b0);
    rate_i = 8'd0;
    repeat (12) step(1'b1, 1'b1, 1'b0);

    // Clear mid-period with a sample in flight.
    rate_i = 8'd4;
    step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b1, 1'b0);

    // Random ratio / shift / density segments.
    for (int s = 0; s < 3; s++) begin
      rate_i  = 8'($urandom_range(2, 12));
      shift_i = 5'($urandom_range(0, 3));
      step(1'b0, 1'b0, 1'b1);
      repeat (80) step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0);
    end

    // Shift beyond the internal width flushes to zero.
    rate_i  = 8'd4;
    shift_i = 5'd30;
    step(1'b0, 1'b0, 1'b1);
    repeat (24) step(1'b1, 1'b1, 1'b0);

    // R=255: saturation without shift, exact value with shift 8.
    rate_i  = 8'd255;
    shift_i = 5'd0;
    step(1'b0, 1'b0, 1'b1);
    repeat (255 * 5) step(1'b1, 1'b1, 1'b0);
    repeat (N + 3) step(1'b0, 1'b0, 1'b0);
    shift_i = 5'd8;
    repeat (255 * 3) step(1'b1, 1'b1, 1'b0);

    // Async reset with the comb pipeline full.
    rate_i  = 8'd4;
    shift_i = 5'd0;
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    reset_checks("midreset");
    #2;
    rstn_i = 1'b1;
    repeat (140) step(1'b1, 1'($urandom), 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
